// File: rtl/cpu_pkg.sv
// Shared CPU-core package: return-stack FSM states and sizing constants
// used by the CPU top to parameterize rstack_ctrl and its RAM.
package cpu_pkg;

   typedef enum logic {
      RS_RUN   = 1'b0,
      RS_FAULT = 1'b1
   } rstack_state_t;

   localparam int RSTACK_WIDTH      = 4;
   localparam int RSTACK_SIZE       = 16;
   localparam int RSTACK_DATA_WIDTH = 13;

endpackage

// File: rtl/rstack_ctrl.sv
// Return-stack controller: stack pointer, depth count and overflow/underflow
// detection for an external 1R1W RAM. Optional macro: RSTACK_GUARD_EN.
module rstack_ctrl
   import cpu_pkg::*;
#(
   parameter int WIDTH      = RSTACK_WIDTH,
   parameter int SIZE       = RSTACK_SIZE,
   parameter int DATA_WIDTH = RSTACK_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic [DATA_WIDTH-1:0] top,
   output logic [WIDTH:0]        depth,
   output logic                  empty,
   output logic                  full,
   output logic                  fault,
   output logic [WIDTH-1:0]      mem_dout_addr,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  we,
   output logic [WIDTH-1:0]      mem_din_addr,
   output logic [DATA_WIDTH-1:0] mem_din
);

   localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(SIZE);

   rstack_state_t    state, state_nxt;
   logic [WIDTH-1:0] wp, wp_nxt;
   logic [WIDTH:0]   cnt, cnt_nxt;
   logic             we_raw;
   logic [WIDTH-1:0] waddr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RS_RUN;
         wp    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         wp    <= wp_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wp_nxt    = wp;
      cnt_nxt   = cnt;
      we_raw    = 1'b0;
      waddr     = wp;
      if (state == RS_RUN) begin
         if (push && pop && (cnt != '0)) begin
            // replace the current top in place
            we_raw = 1'b1;
            waddr  = wp - 1'b1;
         end else if (push) begin
            if (cnt == FULL_CNT) begin
`ifdef RSTACK_GUARD_EN
               state_nxt = RS_FAULT;
`else
               we_raw = 1'b1;
               wp_nxt = wp + 1'b1;
`endif
            end else begin
               we_raw  = 1'b1;
               wp_nxt  = wp + 1'b1;
               cnt_nxt = cnt + 1'b1;
            end
         end else if (pop) begin
            if (cnt == '0) begin
`ifdef RSTACK_GUARD_EN
               state_nxt = RS_FAULT;
`else
               wp_nxt = wp - 1'b1;
`endif
            end else begin
               wp_nxt  = wp - 1'b1;
               cnt_nxt = cnt - 1'b1;
            end
         end
      end
   end

   assign we            = we_raw & ~reset;
   assign mem_din_addr  = waddr;
   assign mem_din       = push_data;
   assign mem_dout_addr = wp - 1'b1;
   assign top           = mem_dout;
   assign depth         = cnt;
   assign empty         = (cnt == '0);
   assign full          = (cnt == FULL_CNT);
`ifdef RSTACK_GUARD_EN
   assign fault         = (state == RS_FAULT);
`else
   assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_rstack_ctrl.sv
// Self-checking bench for rstack_ctrl with a queue-based stack model and a
// behavioural RAM; expectations follow RSTACK_GUARD_EN when defined.
module tb_rstack_ctrl;
   import cpu_pkg::*;

   localparam int W  = RSTACK_WIDTH;
   localparam int S  = RSTACK_SIZE;
   localparam int DW = RSTACK_DATA_WIDTH;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic [DW-1:0] top;
   logic [W:0]    depth;
   logic          empty, full, fault;
   logic [W-1:0]  mem_dout_addr;
   logic [DW-1:0] mem_dout;
   logic          we;
   logic [W-1:0]  mem_din_addr;
   logic [DW-1:0] mem_din;

   logic [DW-1:0] ram [S];

   int checks = 0;
   int errors = 0;

   // reference model: stack contents (back = top), pointer, fault flag
   logic [DW-1:0] q[$];
   int            mwp = 0;
   bit            mfault = 0;

`ifdef RSTACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   rstack_ctrl #(.WIDTH(W), .SIZE(S), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
      .top(top), .depth(depth), .empty(empty), .full(full), .fault(fault),
      .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout), .we(we),
      .mem_din_addr(mem_din_addr), .mem_din(mem_din)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (we) ram[mem_din_addr] <= mem_din;
   assign mem_dout = ram[mem_dout_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("depth", 32'(depth), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == S));
      chk("fault", 32'(fault), 32'(mfault));
      chk("rd_addr", 32'(mem_dout_addr), 32'((mwp + S - 1) % S));
      if (q.size() > 0) chk("top", 32'(top), 32'(q[$]));
   endtask

   // one clock with push/pop applied; checks decode before the edge
   task automatic step(input bit pu, input bit po, input logic [DW-1:0] d);
      bit            exp_we = 0;
      int            exp_addr = 0;
      @(negedge clk);
      reset = 1'b0; push = pu; pop = po; push_data = d;
      #1;
      chk_state();
      if (!mfault) begin
         if (pu && po && q.size() > 0) begin
            exp_we = 1; exp_addr = (mwp + S - 1) % S;
            q[q.size()-1] = d;
         end else if (pu) begin
            if (q.size() == S && GUARD) mfault = 1;
            else begin
               exp_we = 1; exp_addr = mwp;
               if (q.size() == S) void'(q.pop_front());
               q.push_back(d);
               mwp = (mwp + 1) % S;
            end
         end else if (po) begin
            if (q.size() == 0 && GUARD) mfault = 1;
            else begin
               if (q.size() > 0) void'(q.pop_back());
               mwp = (mwp + S - 1) % S;
            end
         end
      end
      chk("we", 32'(we), 32'(exp_we));
      if (exp_we) begin
         chk("wr_addr", 32'(mem_din_addr), 32'(exp_addr));
         chk("wr_data", 32'(mem_din), 32'(d));
      end
      @(posedge clk);
   endtask

   task automatic do_reset(input bit pu, input bit po);
      @(negedge clk);
      reset = 1'b1; push = pu; pop = po; push_data = DW'($urandom);
      #1;
      chk("we_in_reset", 32'(we), 32'd0);
      @(posedge clk);
      q.delete(); mwp = 0; mfault = 0;
      @(negedge clk);
      reset = 1'b0; push = 0; pop = 0;
      #1;
      chk_state();
   endtask

   initial begin
      for (int i = 0; i < S; i++) ram[i] = '0;

      do_reset(0, 0);
      chk("reset_rd_addr", 32'(mem_dout_addr), 32'(S - 1));

      step(1, 0, 13'h0101);
      step(1, 0, 13'h0202);
      step(1, 0, 13'h0303);
      step(0, 0, '0);
      chk("depth3", 32'(depth), 32'd3);
      chk("top0303", 32'(top), 32'h0303);

      step(0, 1, '0);
      step(0, 0, '0);
      chk("top0202", 32'(top), 32'h0202);

      step(1, 1, 13'h1ABC);
      step(0, 0, '0);
      chk("top1abc", 32'(top), 32'h1ABC);
      step(0, 1, '0);
      step(0, 1, '0);
      step(1, 1, 13'h1ABC);
      step(0, 0, '0);
      chk("depth_pp0", 32'(depth), 32'd1);

      do_reset(0, 0);
      for (int i = 0; i < S; i++) step(1, 0, DW'(i));
      step(0, 0, '0);
      chk("full16", 32'(full), 32'd1);
      step(1, 0, 13'h1FFF);
      step(1, 0, 13'h0AAA);
      step(0, 1, '0);
      step(1, 1, 13'h0555);
      step(0, 0, '0);

      do_reset(1, 0);
      step(1, 0, 13'h0777);
      step(0, 0, '0);
      do_reset(0, 0);
      step(0, 1, '0);
      step(0, 1, '0);
      step(1, 0, 13'h0123);
      step(0, 0, '0);

      do_reset(1, 1);
      for (int n = 0; n < 600; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3) do_reset(1'($urandom), 1'($urandom));
         else if (r < 50) step(1, 0, DW'($urandom));
         else if (r < 65) step(1, 1, DW'($urandom));
         else if (r < 90) step(0, 1, '0);
         else step(0, 0, '0);
      end
      step(0, 0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rstack_ctrl.md
Name: rstack_ctrl

Overview:
Return-stack controller for the CPU core. It turns call/return requests into address and write-enable signals for the 1R1W return-stack RAM. The RAM has asynchronous read and synchronous write.
The controller owns the stack pointer and the depth count, presents top-of-stack to the fetch unit, and detects overflow and underflow.
The CPU top instantiates it next to the return-stack RAM.

Parameters:
WIDTH, 4, RAM address width in bits
SIZE, 16, stack depth in entries; must equal 2**WIDTH
DATA_WIDTH, 13, return-address width in bits

Ports:
clk  in  1  system clock; all state changes on posedge
reset  in  1  synchronous reset, active-high
push  in  1  call: store push_data as the new top
pop  in  1  return: discard the current top
push_data  in  DATA_WIDTH  return address to store
top  out  DATA_WIDTH  current top-of-stack; combinational from mem_dout
depth  out  WIDTH+1  number of valid entries, 0..SIZE
empty  out  1  depth==0
full  out  1  depth==SIZE
fault  out  1  sticky overflow/underflow flag; see Optional Feature
mem_dout_addr  out  WIDTH  RAM read address = wp-1 (mod SIZE)
mem_dout  in  DATA_WIDTH  RAM async read data
we  out  1  RAM write enable
mem_din_addr  out  WIDTH  RAM write address
mem_din  out  DATA_WIDTH  RAM write data; always equals push_data

Behaviour:
- State:
  - wp: WIDTH-bit write pointer, wraps mod SIZE.
  - cnt: WIDTH+1-bit depth.
  - FSM state: RS_RUN or RS_FAULT.
- Reset: wp=0, cnt=0, state=RS_RUN. Outputs after reset: depth=0, empty=1, full=0, fault=0, we=0, mem_dout_addr=SIZE-1.
- Decode is combinational from push/pop and the current state. Pointer and count update on the clock edge.
- Push only (push=1, pop=0):
  - we=1, mem_din_addr=wp.
  - Next cycle: wp+1, cnt+1. top shows push_data from the following cycle (1-cycle latency).
- Pop only (pop=1, push=0):
  - we=0. top in the same cycle is the return address; the CPU samples it with pop.
  - Next cycle: wp-1, cnt-1.
- Push and pop together (tail-call / replace):
  - If cnt>0: we=1, mem_din_addr=wp-1; wp and cnt unchanged; top=push_data next cycle.
  - If cnt==0: behaves as push only.
- Neither: we=0, no change.
- Overflow = push only while full. Underflow = pop only while empty. Handling depends on RSTACK_GUARD_EN.
- In RS_FAULT, push and pop are ignored (we=0, wp and cnt hold) until reset.
- Reset asserted in the same cycle as push or pop: reset wins, we=0.

Optional Feature:
Macro: RSTACK_GUARD_EN
- Defined:
  - An overflow or underflow is suppressed: we=0, wp and cnt unchanged.
  - The FSM moves RS_RUN->RS_FAULT and fault=1 from the next cycle. Only reset leaves RS_FAULT.
- Undefined:
  - Ring behaviour. An overflow push writes at wp (overwriting the oldest entry), wp+1, cnt stays SIZE.
  - An underflow pop gives wp-1 and cnt stays 0; top is stale data.
  - RS_FAULT is unreachable and fault is tied 0.

Decomposition:
- Shared package cpu_pkg:
  - typedef enum rstack_state_t {RS_RUN, RS_FAULT}
  - constants RSTACK_WIDTH=4, RSTACK_SIZE=16, RSTACK_DATA_WIDTH=13; the CPU top uses these to parameterize both the controller and the RAM.
- No sub-module: pointer, counter and FSM stay in one file. The RAM is instantiated by the parent, not inside rstack_ctrl.

Test Plan:
- Reset, then push 0x0101, 0x0202, 0x0303 on consecutive cycles -> depth=3; top=0x0303; we pulses with mem_din_addr 0,1,2.
- From depth 3, pop -> top=0x0303 during the pop cycle; next cycle depth=2, top=0x0202.
- Push+pop with push_data=0x1ABC at depth 2 -> we=1, mem_din_addr=1; depth stays 2; top=0x1ABC next cycle. Same at depth 0 -> depth=1.
- Push 16 values 0x0000..0x000F -> full=1, depth=16. Push 0x1FFF:
  - GUARD_EN: we=0, fault=1 next cycle, later pushes and pops ignored, top stays 0x000F.
  - Without GUARD_EN: write at addr 0, depth stays 16, top=0x1FFF.
- Pop at depth 0:
  - GUARD_EN: fault=1, depth=0.
  - Without GUARD_EN: depth stays 0, mem_dout_addr decrements.
- From RS_FAULT, assert reset for one cycle together with push=1 -> depth=0, fault=0, we=0; a normal push works the following cycle.
